// File: rtl/tile_pkg.sv
// Shared constants and state encoding for the tile collector.
package tile_pkg;

    localparam int TILE_DIM   = 4;
    localparam int TILE_ELEMS = TILE_DIM * TILE_DIM;
    localparam int TAG_W      = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/Counter.sv
// Up-counter with synchronous clear; o_co flags the enabled cycle at terminal count.
module Counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_co
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_en) begin
            o_count <= o_count + 1'b1;
        end
    end

    assign o_co = i_en && (o_count == {W{1'b1}});

endmodule

// File: rtl/tile_collector.sv
// Gathers 16 read words into a 4x4 tile and hands it to the consumer over valid/ready.
// Optional sticky protocol-error detection is built when COLLECT_ERR_EN is defined.
module tile_collector
    import tile_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         start_ready,
    input  logic [TAG_W-1:0]             tag_i,
    input  logic [TAG_W-1:0]             tag_k,
    input  logic                         rd_valid,
    input  logic [DATA_W-1:0]            rd_data,
    output logic                         busy,
    output logic                         tile_valid,
    input  logic                         tile_ready,
    output logic [TILE_ELEMS*DATA_W-1:0] tile_data,
    output logic [TAG_W-1:0]             tile_i,
    output logic [TAG_W-1:0]             tile_k,
    output logic                         err
);

    state_t                         r_state;
    logic [TILE_ELEMS*DATA_W-1:0]   r_fill;
    logic [TILE_ELEMS*DATA_W-1:0]   w_fill_bypass;
    logic [TAG_W-1:0]               r_fill_i;
    logic [TAG_W-1:0]               r_fill_k;
    logic [TILE_ELEMS*DATA_W-1:0]   r_tile_data;
    logic [TAG_W-1:0]               r_tile_i;
    logic [TAG_W-1:0]               r_tile_k;
    logic                           r_tile_valid;
    logic [CNT_W-1:0]               w_count;
    logic                           w_last;
    logic                           w_cnt_en;
    logic                           w_start_acc;
    logic                           w_out_free;

    assign w_start_acc = start && (r_state == ST_IDLE);
    assign w_cnt_en    = rd_valid && (r_state == ST_FILL);
    assign w_out_free  = !r_tile_valid || tile_ready;

    Counter #(.W(CNT_W)) u_elem_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_start_acc),
        .i_en    (w_cnt_en),
        .o_count (w_count),
        .o_co    (w_last)
    );

    // Final element goes straight to the output register without a detour through the fill buffer.
    always_comb begin
        w_fill_bypass = r_fill;
        w_fill_bypass[(TILE_ELEMS-1)*DATA_W +: DATA_W] = rd_data;
    end

    // NOTE: the fill buffer has no reset; every slot is rewritten before a tile is handed out.
    always_ff @(posedge clk) begin
        if (w_cnt_en) begin
            r_fill[w_count*DATA_W +: DATA_W] <= rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fill_i     <= '0;
            r_fill_k     <= '0;
            r_tile_data  <= '0;
            r_tile_i     <= '0;
            r_tile_k     <= '0;
            r_tile_valid <= 1'b0;
        end else begin
            // A transfer later in this block overrides the drain-clear.
            if (r_tile_valid && tile_ready) begin
                r_tile_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_fill_i <= tag_i;
                        r_fill_k <= tag_k;
                        r_state  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_last) begin
                        if (w_out_free) begin
                            r_tile_data  <= w_fill_bypass;
                            r_tile_i     <= r_fill_i;
                            r_tile_k     <= r_fill_k;
                            r_tile_valid <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (w_out_free) begin
                        r_tile_data  <= r_fill;
                        r_tile_i     <= r_fill_i;
                        r_tile_k     <= r_fill_k;
                        r_tile_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef COLLECT_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((rd_valid && (r_state != ST_FILL)) || (start && (r_state != ST_IDLE))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign start_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign tile_valid  = r_tile_valid;
    assign tile_data   = r_tile_data;
    assign tile_i      = r_tile_i;
    assign tile_k      = r_tile_k;

endmodule

// File: tb/tb_tile_collector.sv
// Self-checking bench for tile_collector: directed table, corner sequences, random vs. model.
module tb_tile_collector;

    localparam int DW = 8;
`ifdef COLLECT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            start_ready;
    logic [7:0]      tag_i;
    logic [7:0]      tag_k;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            busy;
    logic            tile_valid;
    logic            tile_ready;
    logic [16*DW-1:0] tile_data;
    logic [7:0]      tile_i;
    logic [7:0]      tile_k;
    logic            err;

    always #5 clk = ~clk;

    tile_collector #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_ready (start_ready),
        .tag_i       (tag_i),
        .tag_k       (tag_k),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .tile_valid  (tile_valid),
        .tile_ready  (tile_ready),
        .tile_data   (tile_data),
        .tile_i      (tile_i),
        .tile_k      (tile_k),
        .err         (err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of gathered elements, a "complete tile waiting" flag, and the presented tile.
    bit         m_collect;
    bit         m_held;
    bit         m_out_valid;
    bit         m_err;
    int         m_n;
    logic [7:0] m_elems [16];
    logic [7:0] m_out   [16];
    logic [7:0] m_ti, m_tk, m_oti, m_otk;

    function automatic void model_reset();
        m_collect   = 0;
        m_held      = 0;
        m_out_valid = 0;
        m_err       = 0;
        m_n         = 0;
        m_oti       = '0;
        m_otk       = '0;
        for (int i = 0; i < 16; i++) m_out[i] = '0;
    endfunction

    function automatic void model_deliver();
        m_out       = m_elems;
        m_oti       = m_ti;
        m_otk       = m_tk;
        m_out_valid = 1;
    endfunction

    function automatic void model_edge();
        bit free;
        free = !m_out_valid || tile_ready;
        if ((rd_valid && !m_collect) || (start && (m_collect || m_held))) m_err = 1;
        if (m_out_valid && tile_ready) m_out_valid = 0;
        if (m_held) begin
            if (free) begin
                model_deliver();
                m_held = 0;
            end
        end else if (m_collect) begin
            if (rd_valid) begin
                m_elems[m_n] = rd_data;
                m_n++;
                if (m_n == 16) begin
                    m_collect = 0;
                    if (free) model_deliver();
                    else m_held = 1;
                end
            end
        end else if (start) begin
            m_collect = 1;
            m_n       = 0;
            m_ti      = tag_i;
            m_tk      = tag_k;
        end
    endfunction

    function automatic logic [127:0] model_tile();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_out[i];
        return v;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".start_ready"}, start_ready, !(m_collect || m_held));
        check({tag, ".busy"},        busy,        m_collect || m_held);
        check({tag, ".tile_valid"},  tile_valid,  m_out_valid);
        check({tag, ".tile_data"},   tile_data,   model_tile());
        check({tag, ".tile_i"},      tile_i,      m_oti);
        check({tag, ".tile_k"},      tile_k,      m_otk);
        check({tag, ".err"},         err,         ERR_EN ? m_err : 1'b0);
    endtask

    task automatic drive(input bit s, input logic [7:0] ti, input logic [7:0] tk,
                         input bit v, input logic [7:0] d, input bit rdy);
        start      = s;
        tag_i      = ti;
        tag_k      = tk;
        rd_valid   = v;
        rd_data    = d;
        tile_ready = rdy;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic send_tile(input logic [7:0] ti, input logic [7:0] tk,
                             input logic [7:0] base, input bit rdy, input bit rdy_last);
        drive(1, ti, tk, 0, 8'h00, rdy);
        step("send_start");
        for (int i = 0; i < 16; i++) begin
            drive(0, 8'h00, 8'h00, 1, base + 8'(i), (i == 15) ? rdy_last : rdy);
            step("send_word");
        end
        drive(0, 8'h00, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         start;
        bit         v;
        logic [7:0] d;
        bit         rdy;
        bit         e_sr;
        bit         e_busy;
        bit         e_tv;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // Directed table: start, 16 words, hold one idle cycle, then drain.
        tbl[0] = '{1, 0, 8'h00, 0, 0, 1, 0};
        for (int i = 1; i <= 16; i++) begin
            tbl[i] = '{0, 1, 8'(i - 1), 0, (i == 16), (i != 16), (i == 16)};
        end
        tbl[17] = '{0, 0, 8'h00, 0, 1, 0, 1};
        tbl[18] = '{0, 0, 8'h00, 1, 1, 0, 0};

        drive(0, 8'h00, 8'h00, 0, 8'h00, 0);
        do_reset();
        check("reset.start_ready", start_ready, 1'b1);
        check("reset.busy",        busy,        1'b0);
        check("reset.tile_valid",  tile_valid,  1'b0);
        check("reset.tile_data",   tile_data,   128'h0);
        check("reset.tile_ik",     {tile_i, tile_k}, 16'h0000);
        check("reset.err",         err,         1'b0);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].start, 8'd3, 8'd5, tbl[i].v, tbl[i].d, tbl[i].rdy);
            step("table");
            check($sformatf("table[%0d].start_ready", i), start_ready, tbl[i].e_sr);
            check($sformatf("table[%0d].busy", i),        busy,        tbl[i].e_busy);
            check($sformatf("table[%0d].tile_valid", i),  tile_valid,  tbl[i].e_tv);
            if (i == 16) begin
                check("table.elem_2_1", tile_data[(4*2+1)*8 +: 8], 8'h09);
                check("table.tile_i",   tile_i, 8'd3);
                check("table.tile_k",   tile_k, 8'd5);
            end
        end

        // Output held, second tile fills up and waits.
        send_tile(8'd1, 8'd1, 8'h00, 0, 0);
        send_tile(8'd2, 8'd7, 8'h10, 0, 0);
        check("full.busy",        busy,        1'b1);
        check("full.start_ready", start_ready, 1'b0);
        drive(1, 8'd9, 8'd9, 1, 8'hEE, 0);
        step("full_ignore");
        drive(0, 8'h00, 8'h00, 0, 8'h00, 1);
        step("full_drain");
        check("full.tile_valid", tile_valid, 1'b1);
        check("full.elem_0_0",   tile_data[7:0], 8'h10);
        check("full.tile_ik",    {tile_i, tile_k}, {8'd2, 8'd7});
        step("full_drain2");
        check("full.drained", tile_valid, 1'b0);

        // Drain coincides with the 16th word.
        send_tile(8'd4, 8'd4, 8'h20, 0, 0);
        send_tile(8'd6, 8'd8, 8'h30, 0, 1);
        check("simul.tile_valid", tile_valid, 1'b1);
        check("simul.elem_0_0",   tile_data[7:0], 8'h30);
        check("simul.elem_3_3",   tile_data[15*8 +: 8], 8'h3F);
        check("simul.start_ready", start_ready, 1'b1);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 1);
        step("simul_drain");

        // Alternating rd_valid gaps.
        drive(1, 8'd11, 8'd12, 0, 8'h00, 1);
        step("gap_start");
        for (int i = 0; i < 32; i++) begin
            drive(0, 8'h00, 8'h00, i[0], 8'h50 + 8'(i / 2), 0);
            step("gap_word");
            if (i == 30) check("gap.not_yet", tile_valid, 1'b0);
        end
        check("gap.tile_valid", tile_valid, 1'b1);
        check("gap.elem_1_2",   tile_data[(4*1+2)*8 +: 8], 8'h56);
        check("gap.elem_3_3",   tile_data[15*8 +: 8], 8'h5F);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 1);
        step("gap_drain");

        // Stray data while idle.
        drive(0, 8'h00, 8'h00, 1, 8'hAA, 0);
        step("idle_stray");
        drive(0, 8'h00, 8'h00, 0, 8'h00, 0);
        step("idle_after");
        check("idle.tile_valid", tile_valid, 1'b0);
        check("idle.err",        err,        ERR_EN);

        // Reset in the middle of a tile, then a clean tile.
        drive(1, 8'd13, 8'd14, 0, 8'h00, 0);
        step("rst_start");
        for (int i = 0; i < 7; i++) begin
            drive(0, 8'h00, 8'h00, 1, 8'h70 + 8'(i), 0);
            step("rst_word");
        end
        drive(0, 8'h00, 8'h00, 0, 8'h00, 0);
        rst = 1'b1;
        #1;
        check("midrst.start_ready", start_ready, 1'b1);
        check("midrst.busy",        busy,        1'b0);
        check("midrst.tile_valid",  tile_valid,  1'b0);
        check("midrst.tile_data",   tile_data,   128'h0);
        check("midrst.err",         err,         1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all("post_rst");
        send_tile(8'd21, 8'd22, 8'h80, 1, 1);
        check("fresh.tile_valid", tile_valid, 1'b1);
        check("fresh.elem_0_0",   tile_data[7:0], 8'h80);
        check("fresh.elem_1_3",   tile_data[(4*1+3)*8 +: 8], 8'h87);
        check("fresh.tile_ik",    {tile_i, tile_k}, {8'd21, 8'd22});

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 1) == 1));
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_collector.md
# tile_collector

Downstream companion of the input-buffer address generator. It receives the 16 read-data words that memory returns for one 4x4 tile, assembles them into a packed tile, and presents the tile to the compute array over a valid/ready handshake. A fill buffer plus an output register let the next tile be gathered while the previous one waits for the consumer.

## Interface
- DATA_W, 8, width of one tile element
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request to begin collecting one tile; accepted only when start_ready=1
- start_ready  out  1  high when state is IDLE
- tag_i  in  8  row-block index of the tile, captured on accepted start
- tag_k  in  8  k-block index of the tile, captured on accepted start
- rd_valid  in  1  rd_data carries the next element, in address-generator order
- rd_data  in  DATA_W  memory read data
- busy  out  1  high in FILL or FULL
- tile_valid  out  1  output register holds a tile
- tile_ready  in  1  consumer accepts the tile
- tile_data  out  16*DATA_W  element (r,c) at bits [(4r+c)*DATA_W +: DATA_W]
- tile_i, tile_k  out  8 each  tags of the tile in tile_data
- err  out  1  sticky protocol-error flag (COLLECT_ERR_EN only, else tied 0)

## Operation
- States: IDLE, FILL, FULL.
- IDLE: start=1 -> capture tag_i/tag_k into fill tags, clear element counter e, go FILL.
- FILL: each rd_valid writes rd_data to fill slot e (r=e[3:2], c=e[1:0]) and increments e. start is ignored.
- On rd_valid with e=15: if output free (tile_valid=0, or tile_valid&tile_ready this cycle), load output register from fill buffer with slot 15 bypassed from rd_data, load tags, go IDLE; otherwise write slot 15 and go FULL.
- FULL: when output free, transfer fill buffer and tags to output, go IDLE. rd_valid is dropped.
- Output register: tile_valid set on transfer, cleared on tile_valid&tile_ready unless a transfer occurs in the same cycle, in which case it stays 1 with the new tile.
- rd_valid in IDLE or FULL: data dropped, counter unchanged.
- Counter is 4 bits and wraps 15->0 on the final element.

## Timing
- Reset values: state IDLE, e=0, start_ready=1, busy=0, tile_valid=0, tile_data=0, tile_i=tile_k=0, err=0. Fill buffer not reset.
- Reset mid-operation discards partial and held tiles immediately (asynchronous).
- start accepted at edge N -> busy=1 from cycle N+1; first rd_valid counted at edge N+1 at the earliest.
- Latency: 16th rd_valid sampled at edge M with output free -> tile_valid=1 in cycle M+1, start_ready=1 in cycle M+1.
- Back-to-back throughput: one tile per 17 cycles (start cycle + 16 data cycles) with tile_ready held high.
- tile_data/tile_i/tile_k stable while tile_valid=1 and tile_ready=0.

## Configuration
- COLLECT_ERR_EN defined: err set at edge when rd_valid=1 in IDLE or FULL, or start=1 while not start_ready; cleared only by rst.
- Not defined: err tied 0, no detection logic; data-path behaviour identical.

## Structure
- Shared package tile_pkg: TILE_DIM=4, TILE_ELEMS=16, tag width 8, state encoding typedef (IDLE/FILL/FULL).
- Element counter is the existing Counter module instantiated as Counter #(4) (en = FILL & rd_valid; co marks the final element). No other sub-module; fill and output registers are local.

## Test plan
- Reset then start with tag_i=3, tag_k=5, 16 rd_valid words 0x00..0x0F -> tile_valid one cycle after last word; tile_data element (2,1)=0x09; tile_i=3, tile_k=5.
- tile_ready=0 held; second tile words 0x10..0x1F collected -> state FULL, start_ready=0; raise tile_ready -> first tile drains, next cycle tile_data element (0,0)=0x10, tile_valid stays 1.
- Simultaneous drain and 16th word (tile_ready=1 at edge M) -> tile_valid continuous, new tile in cycle M+1, no lost tile.
- Gaps in rd_valid (e.g. alternating 1/0) -> elements placed in order, tile_valid after 16th valid only.
- rd_valid pulsed in IDLE with 0xAA -> no tile produced, err=1 (with COLLECT_ERR_EN), err=0 without.
- rst asserted after 7 words -> outputs to reset values same cycle; fresh start + 16 words yields correct tile with no residue.
